// File: rtl/fpaddsub_normalize_seq.sv
// fpaddsub_normalize_seq
//
// Sequential post-add normalizer for the FP add/sub datapath. It accepts one
// raw adder result, then shifts it one step per cycle until the hidden bit
// sits in place. A carry-out shifts it right with sticky collection. Leading
// zeros shift it left, either coarsely or one bit at a time. The exponent
// tracks every shift. The result is presented to the rounding stage.
//
// Sum vector layout (VW = `MANTISSA+5):
//   [VW-1] carry, [VW-2] hidden, [VW-3:3] fraction, [2] G, [1] R, [0] S
//
// Configuration macro: NORM_SUBNORMAL_EN
//   defined   -> exponent underflow yields a subnormal (NormE=0, vector kept)
//   undefined -> exponent underflow flushes the result to zero and sets UF
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       operand valid          in_ready   block is idle
//   in_sum         raw adder result       in_exp     pre-normalization exponent
//   in_side        {Sa, Sb, Ctrl, MaxAB}  out_side   in_side captured at accept
//   out_valid      result valid           out_ready  downstream accepts
//   ZeroSum        result is zero         UF         flushed by underflow
//   NormE          normalized exponent (one extra bit, never wraps)
//   NormM          normalized fraction    G, R, S    guard/round/sticky

`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif

module fpaddsub_normalize_seq #(
    parameter int COARSE_SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`MANTISSA+4:0]   in_sum,
    input  logic [`EXPONENT-1:0]   in_exp,
    input  logic [3:0]             in_side,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   ZeroSum,
    output logic [`EXPONENT:0]     NormE,
    output logic [`MANTISSA-1:0]   NormM,
    output logic                   G,
    output logic                   R,
    output logic                   S,
    output logic [3:0]             out_side,
    output logic                   UF
);

    localparam int EW = `EXPONENT;
    localparam int MW = `MANTISSA;
    localparam int VW = MW + 5;
    localparam int CB = VW - 1;   // carry bit
    localparam int HB = VW - 2;   // hidden bit

    localparam logic [EW:0] ONE_E = {{EW{1'b0}}, 1'b1};
    localparam logic [EW:0] CS_E  = (EW + 1)'(COARSE_SHIFT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [VW-1:0]   vec_q, vec_n;
    logic [EW:0]     exp_q, exp_n;
    logic            zero_q, zero_n;
    logic            uf_q, uf_n;
    logic [3:0]      side_q, side_n;

    // Right shift by one; the bit falling off the end is folded into sticky
    // so rounding still sees that something nonzero was discarded.
    function automatic logic [VW-1:0] rshift_sticky(input logic [VW-1:0] v);
        return {1'b0, v[VW-1:2], v[1] | v[0]};
    endfunction

    always_comb begin
        state_n = state;
        vec_n   = vec_q;
        exp_n   = exp_q;
        zero_n  = zero_q;
        uf_n    = uf_q;
        side_n  = side_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    vec_n   = in_sum;
                    exp_n   = {1'b0, in_exp};
                    side_n  = in_side;
                    zero_n  = 1'b0;
                    uf_n    = 1'b0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (vec_q == '0) begin
                    zero_n  = 1'b1;
                    exp_n   = '0;
                    state_n = DONE;
                end else if (vec_q[CB]) begin
                    vec_n = rshift_sticky(vec_q);
                    exp_n = exp_q + ONE_E;
                end else if (vec_q[HB]) begin
                    state_n = DONE;
                end else if (exp_q <= ONE_E) begin
                    // Exponent exhausted before the hidden bit arrived.
`ifdef NORM_SUBNORMAL_EN
                    exp_n   = '0;
`else
                    zero_n  = 1'b1;
                    uf_n    = 1'b1;
                    exp_n   = '0;
                    vec_n   = '0;
`endif
                    state_n = DONE;
                end else if (vec_q[HB -: COARSE_SHIFT] == '0 && exp_q > CS_E) begin
                    // Strict '>' keeps the exponent at 1 or more after a coarse step.
                    vec_n = vec_q << COARSE_SHIFT;
                    exp_n = exp_q - CS_E;
                end else begin
                    vec_n = vec_q << 1;
                    exp_n = exp_q - ONE_E;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // ---- state / working-vector register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            vec_q  <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
            side_q <= '0;
        end else begin
            state  <= state_n;
            vec_q  <= vec_n;
            exp_q  <= exp_n;
            zero_q <= zero_n;
            uf_q   <= uf_n;
            side_q <= side_n;
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign ZeroSum   = zero_q;
    assign NormE     = exp_q;
    assign NormM     = vec_q[HB-1:3];
    assign G         = vec_q[2];
    assign R         = vec_q[1];
    assign S         = vec_q[0];
    assign out_side  = side_q;
    assign UF        = uf_q;

endmodule

// File: tb/tb_fpaddsub_normalize_seq.sv
// Bench for fpaddsub_normalize_seq: directed vectors plus randomized operands
// compared against an arithmetic reference model (leading-zero count and
// exponent budget rather than a step-by-step replica of the shifter).

`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif

module tb_fpaddsub_normalize_seq;

    localparam int EW = `EXPONENT;
    localparam int MW = `MANTISSA;
    localparam int VW = MW + 5;
    localparam int CS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [VW-1:0]     in_sum;
    logic [EW-1:0]     in_exp;
    logic [3:0]        in_side;
    logic              out_valid;
    logic              out_ready;
    logic              zero_sum;
    logic [EW:0]       norm_e;
    logic [MW-1:0]     norm_m;
    logic              g, r, s;
    logic [3:0]        out_side;
    logic              uf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpaddsub_normalize_seq #(.COARSE_SHIFT(CS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_exp    (in_exp),
        .in_side   (in_side),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ZeroSum   (zero_sum),
        .NormE     (norm_e),
        .NormM     (norm_m),
        .G         (g),
        .R         (r),
        .S         (s),
        .out_side  (out_side),
        .UF        (uf)
    );

    task automatic chk(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: leading-zero count decides the normalization shift; the
    // exponent budget decides whether underflow occurs; latency is 2 plus
    // the number of shift cycles (coarse steps taken while both the zero run
    // and the exponent allow).
    task automatic model(input int sum, input int e0,
                         output int z, output int e, output int m,
                         output int grs, output int u, output int lat);
        int v, msb, lz, lr, er, cyc;
        z = 0; u = 0; e = e0; v = sum; lat = 2;
        if (sum == 0) begin
            z = 1; e = 0; v = 0;
        end else if (sum >= (1 << (VW - 1))) begin
            v = (sum >> 1) | (sum & 1);
            e = e0 + 1;
            lat = 3;
        end else begin
            msb = 0;
            for (int i = 0; i < VW - 1; i++)
                if (((sum >> i) & 1) == 1) msb = i;
            lz  = (VW - 2) - msb;
            lr  = lz; er = e0; cyc = 0;
            while (lr > 0 && er > 1) begin
                if (lr >= CS && er > CS) begin lr -= CS; er -= CS; end
                else begin lr -= 1; er -= 1; end
                cyc++;
            end
            lat = 2 + cyc;
            if (lz == 0 || e0 > lz) begin
                v = sum << lz;
                e = e0 - lz;
            end else begin
`ifdef NORM_SUBNORMAL_EN
                v = sum << ((e0 > 0) ? e0 - 1 : 0);
                e = 0;
`else
                v = 0; e = 0; z = 1; u = 1;
`endif
            end
        end
        m   = (v >> 3) & ((1 << MW) - 1);
        grs = v & 7;
    endtask

    task automatic run_op(input int sum, input int e0, input logic [3:0] side,
                          input int hold, input int xz, input int xe, input int xm,
                          input int xgrs, input int xuf, input int xlat, input string nm);
        int lat;
        bit got;
        @(negedge clk);
        chk({nm, ".in_ready"}, int'(in_ready), 1);
        in_sum   = VW'(sum);
        in_exp   = EW'(e0);
        in_side  = side;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (out_valid) begin got = 1'b1; break; end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, ".done"}, int'(got), 1);
        if (!got) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        chk({nm, ".lat"},  lat, xlat);
        chk({nm, ".zero"}, int'(zero_sum), xz);
        chk({nm, ".E"},    int'(norm_e), xe);
        chk({nm, ".M"},    int'(norm_m), xm);
        chk({nm, ".GRS"},  int'({g, r, s}), xgrs);
        chk({nm, ".UF"},   int'(uf), xuf);
        chk({nm, ".side"}, int'(out_side), int'(side));
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            in_sum    = ~in_sum;
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk({nm, ".hold_vld"}, int'(out_valid), 1);
            chk({nm, ".hold_rdy"}, int'(in_ready), 0);
            chk({nm, ".hold_M"},   int'(norm_m), xm);
            chk({nm, ".hold_E"},   int'(norm_e), xe);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, ".rel_vld"}, int'(out_valid), 0);
        chk({nm, ".rel_rdy"}, int'(in_ready), 1);
    endtask

    initial begin
        int z, e, m, grs, u, lat, sum, e0, pos, stray;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sum = '0; in_exp = '0; in_side = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready",  int'(in_ready), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.E",         int'(norm_e), 0);
        chk("rst.M",         int'(norm_m), 0);
        chk("rst.GRS",       int'({g, r, s}), 0);
        chk("rst.zero",      int'(zero_sum), 0);
        chk("rst.UF",        int'(uf), 0);
        chk("rst.side",      int'(out_side), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel.in_ready", int'(in_ready), 1);

        run_op(32'h2008, 15, 4'h5, 0, 0, 15, 32'h001, 0, 0, 2, "hidden");
        run_op(32'h4005, 15, 4'hA, 1, 0, 16, 32'h000, 3, 0, 3, "carry");
        run_op(32'h4005, 31, 4'h3, 0, 0, 32, 32'h000, 3, 0, 3, "carry_max");
        run_op(32'h0010, 20, 4'hC, 0, 0, 11, 32'h000, 0, 0, 5, "coarse");
        run_op(32'h0000,  9, 4'h9, 0, 1,  0, 32'h000, 0, 0, 2, "zero");
`ifdef NORM_SUBNORMAL_EN
        run_op(32'h0100,  3, 4'h6, 0, 0,  0, 32'h080, 0, 0, 4, "underflow");
`else
        run_op(32'h0100,  3, 4'h6, 0, 1,  0, 32'h000, 0, 1, 4, "underflow");
`endif
        run_op(32'h2008, 15, 4'hF, 5, 0, 15, 32'h001, 0, 0, 2, "hold5");

        // Reset in the middle of a long shift sequence abandons the operand.
        @(negedge clk);
        in_sum = VW'(1); in_exp = EW'(30); in_side = 4'h1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.in_ready",  int'(in_ready), 0);
        chk("midrst.out_valid", int'(out_valid), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.rel_rdy", int'(in_ready), 1);
        chk("midrst.E",       int'(norm_e), 0);
        stray = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stray = 1;
        end
        chk("midrst.no_stale", stray, 0);

        for (int t = 0; t < 300; t++) begin
            pos = $urandom_range(0, VW);
            if (pos == VW) sum = 0;
            else sum = (1 << pos) | int'($urandom & ((1 << pos) - 1));
            e0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, (1 << EW) - 1);
            model(sum, e0, z, e, m, grs, u, lat);
            run_op(sum, e0, 4'($urandom), $urandom_range(0, 2), z, e, m, grs, u, lat, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
